// File: rtl/blink_monitor.sv
// Receive-side checker for the blinker LED pattern: synchronises led_in, measures
// intervals between level changes, locks on a stable half-period and flags errors.
module blink_monitor #(
  parameter int CBITS  = 17,
  parameter int TOL    = 2,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             led_in,
  output logic             edge_flg,
  output logic             locked,
  output logic             err,
  output logic             timeout,
  output logic [CBITS:0]   period
);

  typedef enum logic [1:0] {IDLE, MEAS, LOCKED} state_t;

  localparam logic [CBITS:0] HI = (CBITS+1)'((2**CBITS) + TOL);
  localparam logic [CBITS:0] LO = (CBITS+1)'((2**CBITS) - TOL);
  localparam logic [3:0]     LOCK_CNT = 4'(LOCK_N);

  state_t         state, state_n;
  logic           s1, s2, s3;
  logic           edge_det;
  logic [CBITS:0] cnt, cnt_inc;
  logic [3:0]     gcnt, gcnt_n, gcnt_inc;
  logic           good, over;
  logic           err_n, to_n;

  assign edge_det = s2 ^ s3;
  // cnt_inc doubles as the measured interval (cnt+1, saturating)
  assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
  assign good     = (cnt_inc >= LO) && (cnt_inc <= HI);
  assign over     = (cnt > HI);
  assign gcnt_inc = gcnt + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= led_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      period <= '0;
    end else if (edge_det) begin
      cnt    <= '0;
      period <= cnt_inc;
    end else begin
      cnt    <= cnt_inc;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      gcnt     <= '0;
      edge_flg <= 1'b0;
      locked   <= 1'b0;
      err      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gcnt     <= gcnt_n;
      edge_flg <= edge_det;
      locked   <= (state_n == LOCKED);
      err      <= err_n;
      timeout  <= timeout | to_n;
    end
  end

  // An edge always takes priority over the timeout threshold in the same cycle
  always_comb begin
    state_n = state;
    gcnt_n  = gcnt;
    err_n   = 1'b0;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (edge_det) begin
          state_n = MEAS;
          gcnt_n  = '0;
        end
      end
      MEAS: begin
        if (edge_det) begin
          if (good) begin
            gcnt_n = gcnt_inc;
            if (gcnt_inc >= LOCK_CNT) state_n = LOCKED;
          end else begin
            err_n  = 1'b1;
            gcnt_n = '0;
          end
        end else if (over) begin
          err_n   = 1'b1;
          to_n    = 1'b1;
          gcnt_n  = '0;
          state_n = IDLE;
        end
      end
      LOCKED: begin
        if (edge_det) begin
          if (!good) begin
            err_n   = 1'b1;
            gcnt_n  = '0;
            state_n = MEAS;
          end
        end else if (over) begin
          err_n   = 1'b1;
          to_n    = 1'b1;
          gcnt_n  = '0;
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        gcnt_n  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_blink_monitor.sv
// Scoreboard bench for blink_monitor (CBITS=4 => HALF=16, TOL=1, LOCK_N=3).
// Stimulus pushes the expected response of every led_in toggle; a monitor pops on events.
module tb_blink_monitor;

  localparam int CBITS = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             led_in = 1'b0;
  logic             edge_flg, locked, err, timeout;
  logic [CBITS:0]   period;

  typedef struct {
    bit is_edge;
    bit err;
    bit locked;
    bit timeout;
    bit chk_p;
    int per;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  blink_monitor #(.CBITS(CBITS), .TOL(1), .LOCK_N(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .led_in   (led_in),
    .edge_flg (edge_flg),
    .locked   (locked),
    .err      (err),
    .timeout  (timeout),
    .period   (period)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every edge_flg or err pulse must match the next scoreboard entry
  always @(negedge clk) begin
    if (rst && (edge_flg || err)) begin
      if (q.size() == 0) begin
        check("unexpected_event", {30'd0, edge_flg, err}, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("edge_flg", int'(edge_flg), int'(e.is_edge));
        check("err",      int'(err),      int'(e.err));
        check("locked",   int'(locked),   int'(e.locked));
        check("timeout",  int'(timeout),  int'(e.timeout));
        if (e.chk_p) check("period", int'(period), e.per);
      end
    end
  end

  task automatic tog(input int n, input int per, input bit e, input bit l,
                     input bit t, input bit chk);
    exp_t x;
    repeat (n) @(negedge clk);
    led_in = ~led_in;
    x = '{1'b1, e, l, t, chk, per};
    q.push_back(x);
  endtask

  task automatic expect_timeout();
    exp_t x;
    x = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 0};
    q.push_back(x);
  endtask

  task automatic lock_seq(input bit t);
    tog(16, 16, 0, 0, t, 1);
    tog(16, 16, 0, 0, t, 1);
    tog(16, 16, 0, 1, t, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset held while led_in toggles
    for (int i = 0; i < 6; i++) begin
      repeat (3) @(negedge clk);
      led_in = ~led_in;
      check("reset_outputs", int'({edge_flg, locked, err, timeout, period}), 0);
    end
    led_in = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({edge_flg, locked, err, timeout, period}), 0);
    rst = 1'b1;

    // 1+2: reference edge, then lock on the 4th edge
    tog(5, 0, 0, 0, 0, 0);
    lock_seq(0);
    tog(16, 16, 0, 1, 0, 1);

    // 3: long interval at the timeout threshold (edge wins), then relock
    tog(19, 19, 1, 0, 0, 1);
    lock_seq(0);

    // 4: tolerance boundaries
    tog(15, 15, 0, 1, 0, 1);
    tog(17, 17, 0, 1, 0, 1);
    tog(14, 14, 1, 0, 0, 1);
    tog(16, 16, 0, 0, 0, 1);
    tog(18, 18, 1, 0, 0, 1);
    lock_seq(0);

    // 5: stuck input -> one timeout err, then resume from IDLE with saturated period
    expect_timeout();
    repeat (40) @(negedge clk);
    check("timeout_sticky", int'(timeout), 1);
    check("locked_after_to", int'(locked), 0);
    tog(5, 31, 0, 0, 1, 1);
    lock_seq(1);
    tog(16, 16, 0, 1, 1, 1);

    // 6: async reset mid-interval while locked
    repeat (8) @(negedge clk);
    check("queue_before_rst", q.size(), 0);
    check("locked_before_rst", int'(locked), 1);
    #2 rst = 1'b0;
    led_in = 1'b0;
    #1 check("async_reset_outputs", int'({edge_flg, locked, err, timeout, period}), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tog(5, 0, 0, 0, 0, 0);
    lock_seq(0);
    tog(16, 16, 0, 1, 0, 1);

    repeat (6) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
